bga_scan_checker: RTL and testbench

- Parametrised successor to the fixed 86-pin walking-one continuity scanner used on the BGA soldering test board.
- Drives a walking-one or walking-zero pattern across N_PAIR output pins. For each step it compares the looped-back inputs after a programmable dwell time.
- Records first-failure diagnostics, a failure count and a sweep count. Supports single-shot or continuous sweeps under a start/abort handshake.
- Sits between the board pin wrapper and the status/LED logic.

---
 rtl/bga_scan_checker.sv | 187 ++++++++++++++++++
 tb/tb_bga_scan_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bga_scan_checker.sv
// ============================================================================
// Module : bga_scan_checker
// Brief  : Walking-one / walking-zero BGA continuity scanner with first-fail capture.
// Rev    : 1.0  initial parametrised release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bga_scan_checker #(
  parameter int N_PAIR = 86,
  parameter int DWELL  = 32,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              continuous,
  output logic [N_PAIR-1:0] pin_o,
  input  logic [N_PAIR-1:0] pin_i,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              fail_sticky,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [N_PAIR-1:0] fail_diff,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CNT_W-1:0]  sweep_count
);

  localparam int               c_DW_W       = $clog2(DWELL);
  localparam logic [c_DW_W-1:0] c_DWELL_LAST = c_DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]  c_LAST_IDX   = IDX_W'(N_PAIR - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [N_PAIR-1:0] r_sync1;
  logic [N_PAIR-1:0] r_sync2;
  logic              r_mode;
  logic              r_continuous;
  logic [c_DW_W-1:0] r_dwell_cnt;
  logic [N_PAIR-1:0] r_pin_o;
  logic              r_done;
  logic [IDX_W-1:0]  r_cur_idx;
  logic              r_fail_sticky;
  logic [IDX_W-1:0]  r_fail_idx;
  logic [N_PAIR-1:0] r_fail_diff;
  logic [CNT_W-1:0]  r_fail_count;
  logic [CNT_W-1:0]  r_sweep_count;

  logic              w_do_start;
  logic              w_do_abort;
  logic              w_do_step;
  logic              w_at_compare;
  logic              w_last_idx;
  logic              w_mismatch;
  logic [N_PAIR-1:0] w_expect;
  logic [N_PAIR-1:0] w_diff;

  function automatic logic [N_PAIR-1:0] pattern(input logic m, input logic [IDX_W-1:0] k);
    logic [N_PAIR-1:0] oh;
    oh = {{(N_PAIR-1){1'b0}}, 1'b1} << k;
    return m ? ~oh : oh;
  endfunction

  // Loop-back pins are asynchronous to clk; no reset so the chain stays a pure synchroniser.
  always_ff @(posedge clk) begin
    r_sync1 <= pin_i;
    r_sync2 <= r_sync1;
  end

  assign w_at_compare = (r_dwell_cnt == c_DWELL_LAST);
  assign w_last_idx   = (r_cur_idx == c_LAST_IDX);
  assign w_expect     = pattern(r_mode, r_cur_idx);
  assign w_diff       = r_sync2 ^ w_expect;
  assign w_mismatch   = |w_diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_do_start   = 1'b0;
    w_do_abort   = 1'b0;
    w_do_step    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next_state = ST_SCAN;
          w_do_start   = 1'b1;
        end
      end
      ST_SCAN: begin
        // Abort wins over a coinciding compare; that compare is dropped.
        if (abort) begin
          w_next_state = ST_IDLE;
          w_do_abort   = 1'b1;
        end else if (w_at_compare) begin
          w_do_step = 1'b1;
          if (w_last_idx && !r_continuous) w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= 1'b0;
      r_continuous  <= 1'b0;
      r_dwell_cnt   <= '0;
      r_pin_o       <= '0;
      r_done        <= 1'b0;
      r_cur_idx     <= '0;
      r_fail_sticky <= 1'b0;
      r_fail_idx    <= '0;
      r_fail_diff   <= '0;
      r_fail_count  <= '0;
      r_sweep_count <= '0;
    end else if (w_do_start) begin
      r_mode        <= mode;
      r_continuous  <= continuous;
      r_dwell_cnt   <= '0;
      r_pin_o       <= pattern(mode, '0);
      r_done        <= 1'b0;
      r_cur_idx     <= '0;
      r_fail_sticky <= 1'b0;
      r_fail_idx    <= '0;
      r_fail_diff   <= '0;
      r_fail_count  <= '0;
      r_sweep_count <= '0;
    end else if (w_do_abort) begin
      r_dwell_cnt <= '0;
      r_pin_o     <= {N_PAIR{r_mode}};
    end else if (w_do_step) begin
      if (w_mismatch) begin
        r_fail_sticky <= 1'b1;
        if (r_fail_count != c_CNT_MAX) r_fail_count <= r_fail_count + 1'b1;
        if (!r_fail_sticky) begin
          r_fail_idx  <= r_cur_idx;
          r_fail_diff <= w_diff;
        end
      end
      r_dwell_cnt <= '0;
      if (!w_last_idx) begin
        r_cur_idx <= r_cur_idx + 1'b1;
        r_pin_o   <= pattern(r_mode, r_cur_idx + 1'b1);
      end else begin
        if (r_sweep_count != c_CNT_MAX) r_sweep_count <= r_sweep_count + 1'b1;
        if (r_continuous) begin
          r_cur_idx <= '0;
          r_pin_o   <= pattern(r_mode, '0);
        end else begin
          r_done  <= 1'b1;
          r_pin_o <= {N_PAIR{r_mode}};
        end
      end
    end else if (r_state == ST_SCAN) begin
      r_dwell_cnt <= r_dwell_cnt + 1'b1;
    end
  end

  assign pin_o       = r_pin_o;
  assign busy        = (r_state == ST_SCAN);
  assign done        = r_done;
  assign cur_idx     = r_cur_idx;
  assign fail_sticky = r_fail_sticky;
  assign fail_idx    = r_fail_idx;
  assign fail_diff   = r_fail_diff;
  assign fail_count  = r_fail_count;
  assign sweep_count = r_sweep_count;

endmodule

`default_nettype wire

// File: tb/tb_bga_scan_checker.sv
// ============================================================================
// Module : tb_bga_scan_checker
// Brief  : Directed bench for bga_scan_checker with N_PAIR=8, DWELL=4.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bga_scan_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, mode, continuous;
  logic [7:0] pin_o, pin_i;
  logic       busy, done, fail_sticky;
  logic [2:0] cur_idx, fail_idx;
  logic [7:0] fail_diff;
  logic [15:0] fail_count, sweep_count;

  logic       b_start, b_abort, b_mode, b_continuous;
  logic [7:0] b_pin_o;
  logic [7:0] b_pin_i;
  logic       b_busy, b_done, b_fail_sticky;
  logic [2:0] b_cur_idx, b_fail_idx;
  logic [7:0] b_fail_diff;
  logic [1:0] b_fail_count, b_sweep_count;

  int checks = 0;
  int errors = 0;
  int fault  = 0;

  always #5 clk = ~clk;

  // Board fault models applied to the loop-back of the main instance.
  always_comb begin
    pin_i = pin_o;
    case (fault)
      1: pin_i = pin_o & 8'hDF;
      2: begin
        pin_i[3] = pin_o[3] | pin_o[4];
        pin_i[4] = pin_o[3] | pin_o[4];
      end
      3: pin_i = 8'hFF;
      default: pin_i = pin_o;
    endcase
  end

  assign b_pin_i = 8'hFF;

  bga_scan_checker #(.N_PAIR(8), .DWELL(4), .CNT_W(16), .IDX_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .continuous(continuous), .pin_o(pin_o), .pin_i(pin_i), .busy(busy), .done(done),
    .cur_idx(cur_idx), .fail_sticky(fail_sticky), .fail_idx(fail_idx),
    .fail_diff(fail_diff), .fail_count(fail_count), .sweep_count(sweep_count)
  );

  bga_scan_checker #(.N_PAIR(8), .DWELL(4), .CNT_W(2), .IDX_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort), .mode(b_mode),
    .continuous(b_continuous), .pin_o(b_pin_o), .pin_i(b_pin_i), .busy(b_busy), .done(b_done),
    .cur_idx(b_cur_idx), .fail_sticky(b_fail_sticky), .fail_idx(b_fail_idx),
    .fail_diff(b_fail_diff), .fail_count(b_fail_count), .sweep_count(b_sweep_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled on the next edge ("edge 0"); returns 1 time unit after it.
  task automatic pulse_start(input logic m, input logic c);
    start = 1'b1; mode = m; continuous = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; mode = 0; continuous = 0;
    b_start = 0; b_abort = 0; b_mode = 0; b_continuous = 0;
    #2;
    checks++; if (pin_o !== 8'h00) begin errors++; $display("FAIL reset_pin_o: got %h exp 00", pin_o); end
    checks++; if ({busy, done, fail_sticky} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {busy, done, fail_sticky}); end
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({cur_idx, fail_idx} !== 6'd0) begin errors++; $display("FAIL reset_idx: got %h exp 0", {cur_idx, fail_idx}); end
    checks++; if ({fail_diff, fail_count, sweep_count} !== 40'd0) begin errors++; $display("FAIL reset_diag: got %h exp 0", {fail_diff, fail_count, sweep_count}); end
    checks++; if ({b_pin_o, b_busy, b_fail_count, b_sweep_count} !== 13'd0) begin errors++; $display("FAIL reset_sat_inst: got %h exp 0", {b_pin_o, b_busy, b_fail_count, b_sweep_count}); end
  endtask

  task automatic test_clean_sweep();
    logic [7:0] one;
    logic [7:0] exp_pin;
    one = 8'h01;
    fault = 0;
    pulse_start(1'b0, 1'b0);
    for (int e = 0; e <= 32; e++) begin
      exp_pin = (e < 32) ? (one << (e / 4)) : 8'h00;
      checks++; if (pin_o !== exp_pin) begin errors++; $display("FAIL clean_pin_o e=%0d: got %h exp %h", e, pin_o, exp_pin); end
      checks++; if ({busy, done} !== ((e < 32) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL clean_busy_done e=%0d: got %b exp %b", e, {busy, done}, (e < 32) ? 2'b10 : 2'b01); end
      if (e < 32) begin
        checks++; if (cur_idx !== 3'(e / 4)) begin errors++; $display("FAIL clean_cur_idx e=%0d: got %0d exp %0d", e, cur_idx, e / 4); end
        tick();
      end
    end
    checks++; if (fail_sticky !== 1'b0 || fail_count !== 16'd0) begin errors++; $display("FAIL clean_fail: got %b/%0d exp 0/0", fail_sticky, fail_count); end
    checks++; if (sweep_count !== 16'd1) begin errors++; $display("FAIL clean_sweep_count: got %0d exp 1", sweep_count); end
    repeat (3) tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clean_done_sticky: got %b%b exp 10", done, busy); end
  endtask

  task automatic test_walk_zero_stuck();
    int n;
    fault = 1;
    pulse_start(1'b1, 1'b0);
    checks++; if (pin_o !== 8'hFE || done !== 1'b0) begin errors++; $display("FAIL wz_first_pattern: got %h/%b exp fe/0", pin_o, done); end
    n = 0;
    for (int i = 0; i < 100 && !done; i++) begin tick(); n++; end
    checks++; if (done !== 1'b1 || n != 32) begin errors++; $display("FAIL wz_done_edge: got done=%b at %0d exp 1 at 32", done, n); end
    checks++; if (fail_count !== 16'd7) begin errors++; $display("FAIL wz_fail_count: got %0d exp 7", fail_count); end
    checks++; if (fail_idx !== 3'd0 || fail_diff !== 8'h20) begin errors++; $display("FAIL wz_first_fail: got %0d/%h exp 0/20", fail_idx, fail_diff); end
    checks++; if (fail_sticky !== 1'b1 || pin_o !== 8'hFF) begin errors++; $display("FAIL wz_sticky_bg: got %b/%h exp 1/ff", fail_sticky, pin_o); end
  endtask

  task automatic test_short();
    fault = 2;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 100 && !done; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL short_timeout: got done=%b exp 1", done); end
    checks++; if (fail_count !== 16'd2) begin errors++; $display("FAIL short_fail_count: got %0d exp 2", fail_count); end
    checks++; if (fail_idx !== 3'd3 || fail_diff !== 8'h10) begin errors++; $display("FAIL short_first_fail: got %0d/%h exp 3/10", fail_idx, fail_diff); end
  endtask

  task automatic test_abort();
    fault = 0;
    pulse_start(1'b0, 1'b1);
    repeat (69) tick();
    checks++; if (busy !== 1'b1 || sweep_count !== 16'd2) begin errors++; $display("FAIL abort_pre: got %b/%0d exp 1/2", busy, sweep_count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, done} !== 2'b00 || pin_o !== 8'h00) begin errors++; $display("FAIL abort_stop: got %b%b/%h exp 00/00", busy, done, pin_o); end
    checks++; if (sweep_count !== 16'd2 || cur_idx !== 3'd1) begin errors++; $display("FAIL abort_keep: got %0d/%0d exp 2/1", sweep_count, cur_idx); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || cur_idx !== 3'd1 || fail_count !== 16'd0) begin errors++; $display("FAIL abort_idle: got %b/%0d/%0d exp 0/1/0", busy, cur_idx, fail_count); end
    // Abort coinciding with the first compare must drop that compare.
    fault = 3;
    pulse_start(1'b0, 1'b0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (fail_count !== 16'd0 || fail_sticky !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_vs_compare: got %0d/%b/%b exp 0/0/0", fail_count, fail_sticky, busy); end
    abort = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_outside_scan: got busy=%b exp 0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_beats_abort: got busy=%b exp 1", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_saturate();
    b_mode = 1'b0; b_continuous = 1'b1; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (3) tick();
    checks++; if (b_fail_count !== 2'd0) begin errors++; $display("FAIL sat_before_compare: got %0d exp 0", b_fail_count); end
    repeat (9) tick();
    checks++; if (b_fail_count !== 2'd3) begin errors++; $display("FAIL sat_fail_reach: got %0d exp 3", b_fail_count); end
    repeat (4) tick();
    checks++; if (b_fail_count !== 2'd3) begin errors++; $display("FAIL sat_fail_hold: got %0d exp 3", b_fail_count); end
    repeat (80) tick();
    checks++; if (b_sweep_count !== 2'd3) begin errors++; $display("FAIL sat_sweep_reach: got %0d exp 3", b_sweep_count); end
    repeat (32) tick();
    checks++; if (b_sweep_count !== 2'd3 || b_fail_count !== 2'd3 || b_busy !== 1'b1) begin errors++; $display("FAIL sat_hold: got %0d/%0d/%b exp 3/3/1", b_sweep_count, b_fail_count, b_busy); end
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    fault = 3;
    pulse_start(1'b0, 1'b0);
    repeat (9) tick();
    checks++; if (fail_count !== 16'd2 || cur_idx !== 3'd2) begin errors++; $display("FAIL mid_pre_reset: got %0d/%0d exp 2/2", fail_count, cur_idx); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({pin_o, busy, done, cur_idx, fail_sticky} !== 14'd0) begin errors++; $display("FAIL mid_async_reset: got %h exp 0", {pin_o, busy, done, cur_idx, fail_sticky}); end
    checks++; if ({fail_idx, fail_diff, fail_count, sweep_count} !== 43'd0) begin errors++; $display("FAIL mid_async_diag: got %h exp 0", {fail_idx, fail_diff, fail_count, sweep_count}); end
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    fault = 0;
    pulse_start(1'b0, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      start = (e == 5 || e == 13);
      tick();
      start = 1'b0;
      if (e < 32) begin
        checks++; if (cur_idx !== 3'(e / 4) || busy !== 1'b1) begin errors++; $display("FAIL busy_start_idx e=%0d: got %0d/%b exp %0d/1", e, cur_idx, busy, e / 4); end
      end
    end
    checks++; if (done !== 1'b1 || fail_count !== 16'd0 || sweep_count !== 16'd1 || fail_sticky !== 1'b0) begin errors++; $display("FAIL mid_clean_result: got %b/%0d/%0d/%b exp 1/0/1/0", done, fail_count, sweep_count, fail_sticky); end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_walk_zero_stuck();
    test_short();
    test_abort();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
